// File: rtl/score_controller.sv
// Game-state sequencer: IDLE/PLAY/OVER FSM with BCD score and high score,
// display select, blink and leading-zero blanking for the 7-segment scanner.
module score_controller #(
  parameter int BLINK_HALF = 50_000_000,
  parameter int CNT_W      = 26
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        pipe_passed,
  input  logic        collision,
  output logic [15:0] bcd_digits,
  output logic [3:0]  digit_blank,
  output logic [1:0]  game_state,
  output logic        new_high
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_HALF - 1);
  localparam logic [15:0]      SAT     = 16'h9999;

  state_t           state, state_n;
  logic [15:0]      score, score_n;
  logic [15:0]      high, high_n;
  logic [15:0]      shown;
  logic             start_q, start_edge;
  logic [CNT_W-1:0] blink_cnt, blink_cnt_n;
  logic             blink_off, blink_off_n;
  logic             new_high_n;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Units digit is never blanked by the zero rule.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    logic       lead;
    m    = 4'b0000;
    lead = 1'b1;
    for (int i = 3; i > 0; i--) begin
      lead = lead & (v[i*4 +: 4] == 4'd0);
      m[i] = lead;
    end
    return m;
  endfunction

  assign start_edge = start_btn & ~start_q;
  assign game_state = state;

  always_comb begin
    state_n     = state;
    score_n     = score;
    high_n      = high;
    new_high_n  = new_high;
    blink_cnt_n = blink_cnt;
    blink_off_n = blink_off;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          state_n    = PLAY;
          score_n    = '0;
          new_high_n = 1'b0;
        end
      end
      PLAY: begin
        if (collision) begin
          state_n     = OVER;
          blink_cnt_n = '0;
          blink_off_n = 1'b0;
          if (score > high) begin
            high_n     = score;
            new_high_n = 1'b1;
          end
        end else if (pipe_passed && score != SAT) begin
          score_n = bcd_inc(score);
        end
      end
      OVER: begin
        if (start_edge) begin
          state_n = IDLE;
        end else if (blink_cnt == CNT_MAX) begin
          blink_cnt_n = '0;
          blink_off_n = ~blink_off;
        end else begin
          blink_cnt_n = blink_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign shown = (state_n == IDLE) ? high_n : score_n;

  // Display registers follow next-state so they agree with game_state.
  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      state       <= IDLE;
      score       <= '0;
      high        <= '0;
      start_q     <= 1'b0;
      blink_cnt   <= '0;
      blink_off   <= 1'b0;
      new_high    <= 1'b0;
      bcd_digits  <= 16'h0000;
      digit_blank <= 4'b1110;
    end else begin
      state       <= state_n;
      score       <= score_n;
      high        <= high_n;
      start_q     <= start_btn;
      blink_cnt   <= blink_cnt_n;
      blink_off   <= blink_off_n;
      new_high    <= new_high_n;
      bcd_digits  <= shown;
      digit_blank <= (state_n == OVER && blink_off_n) ? 4'b1111
                                                      : lz_mask(shown);
    end
  end

endmodule
